// File: rtl/pe_os_acc_pipe_if.sv
// ----------------------------------------------------------------------------
// pe_os_acc_pipe_if
//
// Purpose : groups the data and control signals of one output-stationary
//           processing element (west/north inputs and east/south outputs)
//           into a single bundle.
//
// Signals :
//   in_a      [A_W]    activation from west
//   in_b      [B_W]    weight from north
//   in_d      [C_W]    preload / drain value from north
//   in_prop   [1]      accumulator select
//   in_shift  [SH_W]   output right-shift amount
//   in_valid  [1]      qualifies all inputs
//   out_a     [A_W]    forwarded a
//   out_b     [B_W]    forwarded b
//   out_c     [OUT_W]  drained, shifted and rounded result
//   out_prop  [1]      forwarded prop
//   out_shift [SH_W]   forwarded shift
//   out_valid [1]      forwarded valid
//
// Modports: master drives the inputs and observes the outputs (neighbour or
//           bench); slave is the processing element itself.
// ----------------------------------------------------------------------------
interface pe_os_acc_pipe_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 19,
  parameter int C_W   = 32,
  parameter int OUT_W = 20,
  parameter int SH_W  = 6
);
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [C_W-1:0]   in_d;
  logic             in_prop;
  logic [SH_W-1:0]  in_shift;
  logic             in_valid;

  logic [A_W-1:0]   out_a;
  logic [B_W-1:0]   out_b;
  logic [OUT_W-1:0] out_c;
  logic             out_prop;
  logic [SH_W-1:0]  out_shift;
  logic             out_valid;

  modport master (
    output in_a, in_b, in_d, in_prop, in_shift, in_valid,
    input  out_a, out_b, out_c, out_prop, out_shift, out_valid
  );

  modport slave (
    input  in_a, in_b, in_d, in_prop, in_shift, in_valid,
    output out_a, out_b, out_c, out_prop, out_shift, out_valid
  );
endinterface

// File: rtl/pe_os_acc_pipe.sv
// ----------------------------------------------------------------------------
// pe_os_acc_pipe
//
// Purpose : parametrised output-stationary PE. Multiplies a (travelling east)
//           by b (travelling south) into one of two ping-pong accumulators
//           while the other accumulator is drained down the column, shifted
//           right with round-half-up and narrowed to OUT_W bits. IN_REGS input
//           stages and OUT_REGS output stages surround the core register, so
//           latency is IN_REGS + 1 + OUT_REGS cycles for every output field.
//
// Ports   :
//   CLK   in  clock, rising edge
//   RST   in  synchronous, active-high reset (clears every register)
//   bus   pe_os_acc_pipe_if.slave  data/control bundle (see interface file)
//
// Build option:
//   PE_OUT_SAT_EN  defined   -> drained value is clamped to signed OUT_W range
//                  undefined -> low OUT_W bits are kept (wrap)
// ----------------------------------------------------------------------------
module pe_os_acc_pipe #(
  parameter int A_W      = 8,
  parameter int B_W      = 19,
  parameter int C_W      = 32,
  parameter int OUT_W    = 20,
  parameter int SH_W     = 6,
  parameter int IN_REGS  = 1,
  parameter int OUT_REGS = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  pe_os_acc_pipe_if.slave        bus
);

  localparam int P_W  = A_W + B_W;
  localparam int IN_W = A_W + B_W + C_W + 1 + SH_W + 1;
  localparam int OV_W = A_W + B_W + OUT_W + 1 + SH_W + 1;

  // Signed OUT_W range expressed at the C_W+1 width of the rounding datapath.
  localparam logic signed [C_W:0] SAT_MAX = (C_W+1)'((longint'(1) << (OUT_W-1)) - 1);
  localparam logic signed [C_W:0] SAT_MIN = -SAT_MAX - 1;

  // --------------------------------------------------------------------------
  // Input stages
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] in_vec;
  logic [IN_W-1:0] core_in;

  assign in_vec = {bus.in_a, bus.in_b, bus.in_d, bus.in_prop, bus.in_shift, bus.in_valid};

  generate
    if (IN_REGS == 0) begin : g_in_bypass
      assign core_in = in_vec;
    end else begin : g_in_regs
      logic [IN_W-1:0] stage_q [IN_REGS];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < IN_REGS; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= in_vec;
          for (int i = 1; i < IN_REGS; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign core_in = stage_q[IN_REGS-1];
    end
  endgenerate

  logic [A_W-1:0]  a_c;
  logic [B_W-1:0]  b_c;
  logic [C_W-1:0]  d_c;
  logic            prop_c;
  logic [SH_W-1:0] shift_c;
  logic            valid_c;

  assign {a_c, b_c, d_c, prop_c, shift_c, valid_c} = core_in;

  // --------------------------------------------------------------------------
  // Core datapath
  // --------------------------------------------------------------------------
  logic [C_W-1:0] c0_q, c0_d;
  logic [C_W-1:0] c1_q, c1_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [OUT_W-1:0] c_q, c_d;
  logic             prop_q, prop_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic             valid_q, valid_d;

  // Full-precision signed product, then sign-extended or truncated to C_W.
  logic signed [P_W-1:0] prod;
  logic        [C_W-1:0] prod_c;

  assign prod   = P_W'($signed(a_c)) * P_W'($signed(b_c));
  assign prod_c = C_W'(prod);

  // prop selects which accumulator is being drained this beat.
  logic [C_W-1:0] drain_src;
  assign drain_src = prop_c ? c0_q : c1_q;

  // Shifts of C_W or more would shift out everything including the sign, so
  // they saturate at C_W-1.
  logic [31:0] sh_eff;
  assign sh_eff = (32'(shift_c) >= C_W) ? 32'(C_W - 1) : 32'(shift_c);

  // Round half up: add 2^(s-1) at one extra bit of headroom, then shift
  // arithmetically.
  logic signed [C_W:0] ext;
  logic signed [C_W:0] rnd_sum;
  logic signed [C_W:0] sr_res;
  logic [OUT_W-1:0]    c_narrow;

  always_comb begin
    ext     = {drain_src[C_W-1], drain_src};
    rnd_sum = ext + ((C_W+1)'(1) << (sh_eff - 32'd1));
    if (sh_eff == 32'd0) begin
      sr_res = ext;
    end else begin
      sr_res = rnd_sum >>> sh_eff;
    end
  end

`ifdef PE_OUT_SAT_EN
  always_comb begin
    if (sr_res > SAT_MAX) begin
      c_narrow = OUT_W'(SAT_MAX);
    end else if (sr_res < SAT_MIN) begin
      c_narrow = OUT_W'(SAT_MIN);
    end else begin
      c_narrow = sr_res[OUT_W-1:0];
    end
  end
`else
  assign c_narrow = sr_res[OUT_W-1:0];
  // Upper bits are deliberately discarded when wrapping.
  logic unused_sr_hi;
  assign unused_sr_hi = &{1'b0, sr_res[C_W:OUT_W], SAT_MIN[0]};
`endif

  always_comb begin
    c0_d    = c0_q;
    c1_d    = c1_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    prop_d  = prop_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (valid_c) begin
      a_d     = a_c;
      b_d     = b_c;
      c_d     = c_narrow;
      prop_d  = prop_c;
      shift_d = shift_c;
      valid_d = 1'b1;
      if (prop_c) begin
        c0_d = d_c;
        c1_d = c1_q + prod_c;
      end else begin
        c1_d = d_c;
        c0_d = c0_q + prod_c;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      c0_q    <= '0;
      c1_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      prop_q  <= 1'b0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      prop_q  <= prop_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output stages
  // --------------------------------------------------------------------------
  logic [OV_W-1:0] core_vec;
  logic [OV_W-1:0] out_vec;

  assign core_vec = {a_q, b_q, c_q, prop_q, shift_q, valid_q};

  generate
    if (OUT_REGS == 0) begin : g_out_bypass
      assign out_vec = core_vec;
    end else begin : g_out_regs
      logic [OV_W-1:0] stage_q [OUT_REGS];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < OUT_REGS; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= core_vec;
          for (int i = 1; i < OUT_REGS; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign out_vec = stage_q[OUT_REGS-1];
    end
  endgenerate

  assign {bus.out_a, bus.out_b, bus.out_c, bus.out_prop, bus.out_shift, bus.out_valid} = out_vec;

endmodule

// File: doc/pe_os_acc_pipe.md
# pe_os_acc_pipe

Parametrised output-stationary processing element for the systolic array. It supersedes the fixed-width PE plus its register wrapper. It multiplies the horizontally travelling `a` by the vertically travelling `b` into one of two ping-pong accumulators, and drains the other accumulator down the column, shifted and rounded. Boundary register stages are configurable, so timing closure and latency are chosen per instance.

## Interface
- `A_W`, 8, signed width of `a`
- `B_W`, 19, signed width of `b`
- `C_W`, 32, accumulator and `d` width
- `OUT_W`, 20, width of `out_c` (must be ≤ `C_W`)
- `SH_W`, 6, shift-amount width
- `IN_REGS`, 1, input register stages (0..3)
- `OUT_REGS`, 1, output register stages (0..3)

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `in_a`  in  `A_W`  activation from west
- `in_b`  in  `B_W`  weight from north
- `in_d`  in  `C_W`  preload/drain value from north
- `in_prop`  in  1  accumulator select
- `in_shift`  in  `SH_W`  output right-shift amount
- `in_valid`  in  1  qualifies all inputs
- `out_a`  out  `A_W`  forwarded `a`
- `out_b`  out  `B_W`  forwarded `b`
- `out_c`  out  `OUT_W`  drained result
- `out_prop`  out  1  forwarded prop
- `out_shift`  out  `SH_W`  forwarded shift
- `out_valid`  out  1  forwarded valid

## Operation
- Input stages: `IN_REGS` register stages carry all inputs, loaded every cycle.
- Core registers: accumulators `c0` and `c1`, plus the registered core outputs.
- On each core cycle with valid=1:
  - prop=1: `out_c` ← sr(`c0`); `c0` ← `d`; `c1` ← `c1` + a·b.
  - prop=0: `out_c` ← sr(`c1`); `c1` ← `d`; `c0` ← `c0` + a·b.
  - `out_a`, `out_b`, `out_prop` and `out_shift` are loaded from the input.
- On each core cycle with valid=0:
  - Accumulators and core data outputs hold.
  - `out_valid` ← 0.
- Arithmetic:
  - a·b is signed, `A_W`+`B_W` bits, sign-extended or truncated to `C_W`.
  - Accumulate wraps modulo 2^`C_W`.
- sr(x, s):
  - s=0: x.
  - Otherwise: (x + 2^(s−1)) >>> s, computed at `C_W`+1 bits, i.e. round half up, arithmetic shift.
  - s ≥ `C_W` is treated as `C_W`−1.
- Narrowing: sr result → `OUT_W`, per Configuration.
- Output stages: `OUT_REGS` stages follow the core and load every cycle.
- Reset: every stage register, both accumulators and every output (`out_a`, `out_b`, `out_c`, `out_prop`, `out_shift`, `out_valid`) are 0 on the cycle after `RST`=1.
  - Reset mid-accumulation discards partial sums.
  - Reset has priority over valid.

## Timing
- Latency from input to output: `IN_REGS` + 1 + `OUT_REGS` cycles, for every output field.
- Throughput: one valid beat per cycle; no back-pressure.
- Accumulator update is visible to a drain one valid core cycle later. Back-to-back prop toggles are legal.
- Valid gaps of any length leave accumulator state unchanged.
- With `IN_REGS`=`OUT_REGS`=0 the block is a single register stage.

## Configuration
- `PE_OUT_SAT_EN` defined: the sr result is clamped to the signed `OUT_W` range [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
- `PE_OUT_SAT_EN` undefined: the low `OUT_W` bits are taken (wrap).

## Test plan
Defaults throughout; latency = 3.
- Reset: drive `RST`=1 for 2 cycles with nonzero inputs → all outputs 0; after release, first valid output appears 3 cycles after its input.
- Accumulate/drain:
  - Stimulus: prop=0, d=5, valid; then 3 beats prop=1, a=3, b=4; then prop=0, shift=0.
  - Response: `out_c`=41 on the last beat's output.
  - Values: the 2nd and 4th beats drain `c0`=0; ping-pong is correct.
- Rounding:
  - `c1`=41 drained with shift=2 → `out_c`=10.
  - `c1`=−41 drained with shift=2 → `out_c`=−10.
- Narrowing: `c1`=1048576 drained with shift=0 → `out_c`=524287 with `PE_OUT_SAT_EN`, 0 without.
- Valid gap:
  - Stimulus: 2 accumulate beats of a=2, b=2, then 5 cycles valid=0, then a drain.
  - Response: drained value 8; `out_valid`=0 for exactly the 5 gap cycles at the output.
- Reset mid-operation:
  - Stimulus: assert `RST` between 2nd and 3rd accumulate beat of a=3, b=4 (prior sum 24), then one more beat and a drain.
  - Response: drain gives 12.
